// File: rtl/jtag_master_if.sv
// Command/response channel between a host controller and jtag_master.
// The host side drives commands; the JTAG engine answers with captured TDO.
interface jtag_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic        rsp_valid;
    logic [31:0] rsp_tdo;
    logic        busy;

    modport master (
        output cmd_valid,
        output cmd_len,
        output cmd_tms,
        output cmd_tdi,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_tdo,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_len,
        input  cmd_tms,
        input  cmd_tdi,
        output cmd_ready,
        output rsp_valid,
        output rsp_tdo,
        output busy
    );
endinterface

// File: rtl/jtag_master.sv
// Host-side JTAG initiator: shifts up to 32 bits of TMS/TDI per command
// and returns the TDO bits sampled on each TCK rising edge.
module jtag_master #(
    parameter int CLK_DIV = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    jtag_master_if.slave  bus,
    output logic          jtag_tck_o,
    output logic          jtag_tms_o,
    output logic          jtag_tdi_o,
    input  logic          jtag_tdo_i
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] div_cnt;
    logic [4:0]    bit_idx;
    logic [4:0]    len_q;
    logic [31:0]   tms_q;
    logic [31:0]   tdi_q;
    logic [31:0]   tdo_sr;
    logic [31:0]   rsp_tdo_q;
    logic          accept;
    logic          phase_end;
    logic          last_bit;

    always_comb begin
        accept    = (state == IDLE) && bus.cmd_valid;
        phase_end = (div_cnt == DIV_LAST);
        last_bit  = (bit_idx == len_q);
        state_n   = state;
        unique case (state)
            IDLE:    if (accept) state_n = LOW;
            LOW:     if (phase_end) state_n = HIGH;
            HIGH:    if (phase_end) state_n = last_bit ? DONE : LOW;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Phase counter restarts on every state change so each phase is CLK_DIV long.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
        end else if (state_n != state) begin
            div_cnt <= '0;
        end else if (state == LOW || state == HIGH) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q      <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            tdo_sr     <= '0;
            bit_idx    <= '0;
            rsp_tdo_q  <= '0;
            jtag_tck_o <= 1'b0;
            jtag_tms_o <= 1'b1;
            jtag_tdi_o <= 1'b0;
        end else begin
            jtag_tck_o <= (state_n == HIGH);
            if (accept) begin
                len_q      <= bus.cmd_len;
                tms_q      <= bus.cmd_tms;
                tdi_q      <= bus.cmd_tdi;
                tdo_sr     <= '0;
                bit_idx    <= '0;
                jtag_tms_o <= bus.cmd_tms[0];
                jtag_tdi_o <= bus.cmd_tdi[0];
            end
            // The LOW->HIGH edge is the TCK rising edge seen by the target.
            if (state == LOW && phase_end) begin
                tdo_sr[bit_idx] <= jtag_tdo_i;
            end
            if (state == HIGH && phase_end && !last_bit) begin
                bit_idx    <= bit_idx + 5'd1;
                jtag_tms_o <= tms_q[bit_idx + 5'd1];
                jtag_tdi_o <= tdi_q[bit_idx + 5'd1];
            end
            if (state_n == DONE) begin
                rsp_tdo_q <= tdo_sr;
            end
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_tdo   = rsp_tdo_q;

endmodule
